// File: rtl/game_pkg.sv
// Shared encodings for the frame game controller: FSM states as seen on the state output
// and the width of the lives field.
package game_pkg;

  localparam int unsigned LIVES_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAY     = 2'd1,
    ST_HIT      = 2'd2,
    ST_GAMEOVER = 2'd3
  } game_state_e;

endpackage

// File: rtl/frame_game_controller_if.sv
// Frame/collision inputs and game status outputs of the frame game controller.
// The controller uses the slave modport; whoever drives frames and collisions uses master.
interface frame_game_controller_if;
  import game_pkg::*;

  logic                frame_end;
  logic                player_dragon_col;
  logic                sword_dragon_col;
  logic                sheep_dragon_col;
  logic                start_btn;
  game_state_e         state;
  logic [LIVES_W-1:0]  lives;
  logic                game_active;
  logic                invuln;
  logic                player_hit;
  logic                dragon_hit;
  logic                dragon_heal;
  logic                game_restart;

  modport master (
    output frame_end, player_dragon_col, sword_dragon_col, sheep_dragon_col, start_btn,
    input  state, lives, game_active, invuln, player_hit, dragon_hit, dragon_heal, game_restart
  );

  modport slave (
    input  frame_end, player_dragon_col, sword_dragon_col, sheep_dragon_col, start_btn,
    output state, lives, game_active, invuln, player_hit, dragon_hit, dragon_heal, game_restart
  );

endinterface

// File: rtl/frame_event_latch.sv
// Sticky per-frame flag: ORs a collision level over a frame and flags a rising edge
// relative to the previous frame's accumulated value.
module frame_event_latch (
  input  logic clk,
  input  logic reset,
  input  logic frame_end_i,
  input  logic col_i,
  output logic seen_o,
  output logic rise_o
);

  logic acc_q, prev_q;

  // The frame_end cycle's own input counts toward the frame being evaluated.
  assign seen_o = acc_q | col_i;
  assign rise_o = seen_o & ~prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= 1'b0;
      prev_q <= 1'b0;
    end else if (frame_end_i) begin
      acc_q  <= 1'b0;
      prev_q <= seen_o;
    end else begin
      acc_q  <= seen_o;
    end
  end

endmodule

// File: rtl/frame_game_controller.sv
// Per-frame game sequencer: evaluates accumulated collisions at frame_end and owns lives,
// the invulnerability window and the title/play/game-over sequence.
module frame_game_controller
  import game_pkg::*;
#(
  parameter int unsigned MAX_LIVES     = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned GAMEOVER_HOLD = 120,
  parameter int unsigned CNT_W         = 7
) (
  input logic                    clk,
  input logic                    reset,
  frame_game_controller_if.slave bus
);

  localparam int unsigned MaxCnt   = (1 << CNT_W) - 1;
  localparam int unsigned MaxLives = (1 << LIVES_W) - 1;

  if (MAX_LIVES < 1 || MAX_LIVES > MaxLives || INVULN_FRAMES < 1 || INVULN_FRAMES > MaxCnt ||
      GAMEOVER_HOLD < 1 || GAMEOVER_HOLD > MaxCnt) begin : gen_param_check
    $error("frame_game_controller: parameter out of range for LIVES_W/CNT_W");
  end

  logic seen_p, seen_s, seen_h, rise_s, rise_h;
  logic unused_rise_p;

  frame_event_latch u_player (
    .clk        (clk),
    .reset      (reset),
    .frame_end_i(bus.frame_end),
    .col_i      (bus.player_dragon_col),
    .seen_o     (seen_p),
    .rise_o     (unused_rise_p)
  );

  frame_event_latch u_sword (
    .clk        (clk),
    .reset      (reset),
    .frame_end_i(bus.frame_end),
    .col_i      (bus.sword_dragon_col),
    .seen_o     (seen_s),
    .rise_o     (rise_s)
  );

  frame_event_latch u_sheep (
    .clk        (clk),
    .reset      (reset),
    .frame_end_i(bus.frame_end),
    .col_i      (bus.sheep_dragon_col),
    .seen_o     (seen_h),
    .rise_o     (rise_h)
  );

  logic               start_s1_q, start_s2_q, start_prev_q, start_edge;
  game_state_e        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               player_hit_q, player_hit_d, dragon_hit_q, dragon_hit_d;
  logic               dragon_heal_q, dragon_heal_d, restart_q, restart_d;

  // The button edge is judged frame-to-frame, not cycle-to-cycle.
  assign start_edge = start_s2_q & ~start_prev_q;

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    cnt_d         = cnt_q;
    player_hit_d  = 1'b0;
    dragon_hit_d  = 1'b0;
    dragon_heal_d = 1'b0;
    restart_d     = 1'b0;
    if (bus.frame_end) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            state_d   = ST_PLAY;
            lives_d   = LIVES_W'(MAX_LIVES);
            restart_d = 1'b1;
          end
        end
        ST_PLAY: begin
          dragon_hit_d  = rise_s;
          dragon_heal_d = rise_h;
          if (seen_p) begin
            player_hit_d = 1'b1;
            if (lives_q > LIVES_W'(1)) begin
              lives_d = lives_q - 1'b1;
              cnt_d   = CNT_W'(INVULN_FRAMES);
              state_d = ST_HIT;
            end else begin
              lives_d = '0;
              cnt_d   = CNT_W'(GAMEOVER_HOLD);
              state_d = ST_GAMEOVER;
            end
          end
        end
        ST_HIT: begin
          dragon_hit_d  = rise_s;
          dragon_heal_d = rise_h;
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d   = cnt_q - 1'b1;
          end
        end
        ST_GAMEOVER: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (start_edge) begin
            state_d   = ST_PLAY;
            lives_d   = LIVES_W'(MAX_LIVES);
            restart_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_s1_q    <= 1'b0;
      start_s2_q    <= 1'b0;
      start_prev_q  <= 1'b0;
      state_q       <= ST_IDLE;
      lives_q       <= LIVES_W'(MAX_LIVES);
      cnt_q         <= '0;
      player_hit_q  <= 1'b0;
      dragon_hit_q  <= 1'b0;
      dragon_heal_q <= 1'b0;
      restart_q     <= 1'b0;
    end else begin
      start_s1_q    <= bus.start_btn;
      start_s2_q    <= start_s1_q;
      if (bus.frame_end) start_prev_q <= start_s2_q;
      state_q       <= state_d;
      lives_q       <= lives_d;
      cnt_q         <= cnt_d;
      player_hit_q  <= player_hit_d;
      dragon_hit_q  <= dragon_hit_d;
      dragon_heal_q <= dragon_heal_d;
      restart_q     <= restart_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.lives        = lives_q;
  assign bus.game_active  = (state_q == ST_PLAY) || (state_q == ST_HIT);
  assign bus.invuln       = (state_q == ST_HIT);
  assign bus.player_hit   = player_hit_q;
  assign bus.dragon_hit   = dragon_hit_q;
  assign bus.dragon_heal  = dragon_heal_q;
  assign bus.game_restart = restart_q;

endmodule

// File: tb/tb_frame_game_controller.sv
// Bench for frame_game_controller: a hand-derived vector table, directed multi-frame
// sequences and randomized frames, all checked cycle by cycle against a frame-level model.
module tb_frame_game_controller;
  import game_pkg::*;

  localparam int MAXL = 3;
  localparam int INV  = 60;
  localparam int HOLD = 120;
  localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_OVER = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_game_controller_if bus ();

  frame_game_controller #(
    .MAX_LIVES    (MAXL),
    .INVULN_FRAMES(INV),
    .GAMEOVER_HOLD(HOLD),
    .CNT_W        (7)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_ph = 0, cnt_dh = 0, cnt_heal = 0, cnt_rs = 0;

  // Reference model: game mode, lives, frames left, what was seen this frame and last frame.
  int m_mode, m_lives, m_cnt;
  bit seen_p, seen_s, seen_h, last_s, last_h, last_btn;
  bit e_ph, e_dh, e_heal, e_rs;
  bit hist[$];

  typedef struct {
    bit rst, fe, p, s, h, btn;
    int st, lv;
    bit [3:0] pulses;  // {player_hit, dragon_hit, dragon_heal, game_restart}
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit fe, input bit p, input bit s,
                            input bit h, input bit btn);
    bit synced, st_edge, new_s, new_h;
    {e_ph, e_dh, e_heal, e_rs} = 4'b0000;
    if (rst) begin
      m_mode = M_IDLE; m_lives = MAXL; m_cnt = 0;
      {seen_p, seen_s, seen_h, last_s, last_h, last_btn} = 6'b0;
      hist.delete();
      return;
    end
    synced = (hist.size() == 2) ? hist[0] : 1'b0;  // button value two clocks ago
    hist.push_back(btn);
    if (hist.size() > 2) void'(hist.pop_front());
    seen_p |= p; seen_s |= s; seen_h |= h;
    if (fe) begin
      st_edge  = synced && !last_btn;
      last_btn = synced;
      new_s    = seen_s && !last_s;
      new_h    = seen_h && !last_h;
      case (m_mode)
        M_IDLE: if (st_edge) begin m_mode = M_PLAY; m_lives = MAXL; e_rs = 1; end
        M_PLAY: begin
          e_dh = new_s; e_heal = new_h;
          if (seen_p) begin
            e_ph = 1;
            m_lives = m_lives - 1;
            if (m_lives == 0) begin m_mode = M_OVER; m_cnt = HOLD; end
            else begin m_mode = M_HIT; m_cnt = INV; end
          end
        end
        M_HIT: begin
          e_dh = new_s; e_heal = new_h;
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_mode = M_PLAY;
        end
        default: begin
          if (m_cnt > 0) m_cnt = m_cnt - 1;
          else if (st_edge) begin m_mode = M_PLAY; m_lives = MAXL; e_rs = 1; end
        end
      endcase
      last_s = seen_s; last_h = seen_h;
      {seen_p, seen_s, seen_h} = 3'b000;
    end
  endtask

  function automatic logic [9:0] obs();
    return {bus.state, bus.lives, bus.game_active, bus.invuln,
            bus.player_hit, bus.dragon_hit, bus.dragon_heal, bus.game_restart};
  endfunction

  function automatic logic [9:0] model_vec();
    bit ga, inv;
    ga  = (m_mode == M_PLAY) || (m_mode == M_HIT);
    inv = (m_mode == M_HIT);
    return {2'(m_mode), 2'(m_lives), ga, inv, e_ph, e_dh, e_heal, e_rs};
  endfunction

  task automatic tick(input bit rst, input bit fe, input bit p, input bit s, input bit h,
                      input bit btn);
    @(negedge clk);
    reset = rst; bus.frame_end = fe; bus.player_dragon_col = p;
    bus.sword_dragon_col = s; bus.sheep_dragon_col = h; bus.start_btn = btn;
    @(posedge clk);
    model_step(rst, fe, p, s, h, btn);
    #1;
    cnt_ph   += int'(bus.player_hit);
    cnt_dh   += int'(bus.dragon_hit);
    cnt_heal += int'(bus.dragon_heal);
    cnt_rs   += int'(bus.game_restart);
    check("model", 32'(obs()), 32'(model_vec()));
  endtask

  task automatic frame(input int len, input bit p, input bit s, input bit h, input bit btn);
    for (int i = 0; i < len; i++) tick(1'b0, i == len - 1, p, s, h, btn);
  endtask

  task automatic frames(input int n, input bit p, input bit s, input bit h, input bit btn);
    for (int i = 0; i < n; i++) frame(4, p, s, h, btn);
  endtask

  int start_rs, start_dh;
  int len;
  bit rbtn, rrst;

  initial begin
    bus.frame_end = 0; bus.player_dragon_col = 0; bus.sword_dragon_col = 0;
    bus.sheep_dragon_col = 0; bus.start_btn = 0;

    //           rst fe p  s  h  btn st lv pulses
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 3, 4'b0000};
    tbl[1]  = '{0, 0, 0, 0, 0, 1, 0, 3, 4'b0000};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 0, 3, 4'b0000};
    tbl[3]  = '{0, 1, 0, 0, 0, 1, 1, 3, 4'b0001};
    tbl[4]  = '{0, 0, 0, 0, 0, 1, 1, 3, 4'b0000};
    tbl[5]  = '{0, 1, 0, 0, 0, 1, 1, 3, 4'b0000};
    tbl[6]  = '{0, 0, 1, 0, 0, 0, 1, 3, 4'b0000};
    tbl[7]  = '{0, 1, 0, 0, 0, 0, 2, 2, 4'b1000};
    tbl[8]  = '{0, 1, 0, 1, 1, 0, 2, 2, 4'b0110};
    tbl[9]  = '{0, 1, 0, 1, 0, 0, 2, 2, 4'b0000};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 2, 2, 4'b0000};
    tbl[11] = '{0, 1, 0, 1, 1, 0, 2, 2, 4'b0110};
    tbl[12] = '{1, 1, 1, 0, 0, 0, 0, 3, 4'b0000};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 3, 4'b0000};
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].rst, tbl[i].fe, tbl[i].p, tbl[i].s, tbl[i].h, tbl[i].btn);
      check($sformatf("tbl%0d", i),
            32'({bus.state, bus.lives, bus.player_hit, bus.dragon_hit, bus.dragon_heal,
                 bus.game_restart}),
            32'({2'(tbl[i].st), 2'(tbl[i].lv), tbl[i].pulses}));
    end

    // Start held across two frame_ends gives a single restart.
    tick(1, 0, 0, 0, 0, 0);
    start_rs = cnt_rs;
    frames(2, 0, 0, 0, 1);
    check("start_once", 32'(cnt_rs - start_rs), 32'd1);
    check("start_state", 32'(bus.state), 32'(M_PLAY));

    // Hit, then continuous contact through the invulnerability window.
    frames(1, 1, 0, 0, 0);
    check("hit_lives", 32'(bus.lives), 32'd2);
    check("hit_invuln", 32'(bus.invuln), 32'd1);
    frames(INV - 1, 1, 0, 0, 0);
    check("window_state", 32'(bus.state), 32'(M_HIT));
    check("window_lives", 32'(bus.lives), 32'd2);
    frames(1, 0, 0, 0, 0);
    check("window_end", 32'(bus.state), 32'(M_PLAY));

    // Down to game over; early start is ignored, late start restarts.
    frames(1, 1, 0, 0, 0);
    frames(INV, 0, 0, 0, 0);
    frames(1, 1, 0, 0, 0);
    check("over_state", 32'(bus.state), 32'(M_OVER));
    check("over_lives", 32'(bus.lives), 32'd0);
    start_rs = cnt_rs;
    frames(48, 0, 0, 0, 0);
    frames(2, 0, 0, 0, 1);
    frames(80, 0, 0, 0, 0);
    check("hold_ignore", 32'(cnt_rs - start_rs), 32'd0);
    check("hold_state", 32'(bus.state), 32'(M_OVER));
    frames(1, 0, 0, 0, 1);
    check("restart_state", 32'(bus.state), 32'(M_PLAY));
    check("restart_lives", 32'(bus.lives), 32'd3);
    check("restart_pulse", 32'(cnt_rs - start_rs), 32'd1);

    // Long sword contact is one event; a gap re-arms it.
    start_dh = cnt_dh;
    frames(10, 0, 1, 0, 0);
    check("sword_once", 32'(cnt_dh - start_dh), 32'd1);
    frames(1, 0, 0, 0, 0);
    frames(1, 0, 1, 0, 0);
    check("sword_again", 32'(cnt_dh - start_dh), 32'd2);
    frames(1, 0, 0, 0, 0);

    // Final life lost together with both dragon events.
    frames(1, 1, 0, 0, 0);
    frames(INV, 0, 0, 0, 0);
    frames(1, 1, 0, 0, 0);
    frames(INV, 0, 0, 0, 0);
    check("one_life", 32'(bus.lives), 32'd1);
    frames(1, 1, 1, 1, 0);
    check("simul_pulses", 32'({bus.player_hit, bus.dragon_hit, bus.dragon_heal}), 32'b111);
    check("simul_state", 32'({bus.state, bus.lives}), 32'({2'(M_OVER), 2'd0}));

    // Reset wins over a frame_end with collision during HIT.
    tick(1, 0, 0, 0, 0, 0);
    frames(1, 0, 0, 0, 1);
    frames(1, 1, 0, 0, 0);
    tick(1, 1, 1, 1, 1, 0);
    check("rst_prio", 32'(obs()), 32'({2'(M_IDLE), 2'd3, 6'b000000}));

    // Randomized frames with occasional resets.
    for (int f = 0; f < 1500; f++) begin
      len  = $urandom_range(1, 4);
      rbtn = ($urandom_range(0, 2) == 0);
      rrst = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < len; c++)
        tick(rrst && c == 0, c == len - 1, $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, rbtn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
